led_pattern_ctrl: RTL

Button-driven controller for the ULX3S 8-LED bank. It debounces the board buttons and runs a mode state machine that chooses one of four LED patterns. It also owns a programmable step-rate prescaler and a pause control, and drives a registered `led[7:0]` bus. It replaces a free-running LED pattern with one the user can control, and sits directly between the board pins and the LED outputs.

---
 rtl/led_pattern_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: debounced button control of a four-mode, rate-adjustable LED pattern generator
module led_pattern_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SPEED_BASE      = 22
) (
    input  logic       clk_25mhz,
    input  logic       rst_n,
    input  logic [6:0] btn,
    output logic [7:0] led,
    output logic [1:0] mode,
    output logic [2:0] speed,
    output logic       paused
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {SWEEP, COUNT, FILL, BLINK} mode_t;

    logic [3:0]             r_sync1, r_sync2, r_deb, r_press;
    logic [3:0][CW-1:0]     r_dcnt;
    logic [SPEED_BASE-1:0]  r_pre;
    logic [SPEED_BASE-1:0]  w_mask;
    logic                   w_tick, w_mode_p, w_up, w_dn, w_pause_p, w_unused;
    mode_t                  r_mode;
    logic [2:0]             r_pos;
    logic                   r_dir;
    logic [7:0]             r_cnt;
    logic [3:0]             r_fill;
    logic                   r_blink;
    logic [2:0]             r_speed;
    logic                   r_paused;

    assign w_unused = ^{btn[6:5], btn[0]};
    assign {w_pause_p, w_dn, w_up, w_mode_p} = r_press;
    assign w_mask = {SPEED_BASE{1'b1}} >> r_speed;
    assign w_tick = (r_pre & w_mask) == w_mask;
    assign mode   = r_mode;
    assign speed  = r_speed;
    assign paused = r_paused;

    // Synchronise and debounce btn[4:1]; a debounced rise emits a one-cycle press
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_press <= '0;
            r_dcnt  <= '0;
        end else begin
            r_sync1 <= btn[4:1];
            r_sync2 <= r_sync1;
            for (int i = 0; i < 4; i++) begin
                r_press[i] <= 1'b0;
                if (r_sync2[i] == r_deb[i]) begin
                    r_dcnt[i] <= '0;
                end else if (r_dcnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_deb[i]   <= r_sync2[i];
                    r_press[i] <= r_sync2[i];
                    r_dcnt[i]  <= '0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + 1'b1;
                end
            end
        end
    end

    // Free-running step prescaler; never restarted so speed changes take effect on the next mask match
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) r_pre <= '0;
        else        r_pre <= r_pre + 1'b1;
    end

    // Saturating speed level and pause toggle; opposing up/down presses cancel
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_speed  <= 3'd3;
            r_paused <= 1'b0;
        end else begin
            if (w_up && !w_dn && r_speed != 3'd7)      r_speed <= r_speed + 1'b1;
            else if (w_dn && !w_up && r_speed != 3'd0) r_speed <= r_speed - 1'b1;
            if (w_pause_p) r_paused <= ~r_paused;
        end
    end

    // Mode FSM and pattern state; a mode press reinitialises the pattern and swallows a same-cycle tick
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= SWEEP;
            r_pos   <= '0;
            r_dir   <= 1'b0;
            r_cnt   <= '0;
            r_fill  <= '0;
            r_blink <= 1'b1;
        end else if (w_mode_p) begin
            r_mode  <= mode_t'(r_mode + 2'd1);
            r_pos   <= '0;
            r_dir   <= 1'b0;
            r_cnt   <= '0;
            r_fill  <= '0;
            r_blink <= 1'b1;
        end else if (w_tick && !r_paused) begin
            case (r_mode)
                SWEEP: begin
                    r_pos <= r_dir ? r_pos - 1'b1 : r_pos + 1'b1;
                    r_dir <= r_dir ? (r_pos != 3'd1) : (r_pos == 3'd6);
                end
                COUNT: r_cnt   <= r_cnt + 1'b1;
                FILL:  r_fill  <= (r_fill == 4'd8) ? 4'd0 : r_fill + 1'b1;
                BLINK: r_blink <= ~r_blink;
            endcase
        end
    end

    // Register the LED bus from the current pattern state
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) led <= '0;
        else        led <= (r_mode == SWEEP) ? 8'd1 << r_pos :
                           (r_mode == COUNT) ? r_cnt :
                           (r_mode == FILL)  ? ~(8'hFF << r_fill) : {8{r_blink}};
    end
endmodule
